// File: rtl/scan_mux.sv
// Registered N-channel, W-bit multiplexer with manual select and round-robin auto-scan.
// Each lane gates its own channel onto an AND-OR tree; the selected word is registered into y.

module scan_mux_lane #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 2,
  parameter int IDX   = 0
) (
  input  logic [SEL_W-1:0] sel,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] q
);
  assign q = (sel == SEL_W'(IDX)) ? data : '0;
endmodule

module scan_mux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int DWELL    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      mode,
  input  logic                      load,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] in_bus,
  output logic [WIDTH-1:0]          y,
  output logic                      y_valid,
  output logic [SEL_W-1:0]          cur_sel,
  output logic                      wrap
);
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SEL_W-1:0] LAST     = SEL_W'(CHANNELS - 1);
  localparam logic [CW-1:0]    CNT_LAST = CW'(DWELL - 1);

  logic [CHANNELS-1:0][WIDTH-1:0] lane_q;
  logic [WIDTH-1:0]               y_nxt;
  logic [SEL_W-1:0]               sel_c;
  logic [CW-1:0]                  cnt;
  logic                           mode_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    scan_mux_lane #(.WIDTH(WIDTH), .SEL_W(SEL_W), .IDX(i)) u_lane (
      .sel  (cur_sel),
      .data (in_bus[i*WIDTH +: WIDTH]),
      .q    (lane_q[i])
    );
  end

  always_comb begin
    y_nxt = '0;
    for (int i = 0; i < CHANNELS; i++) y_nxt |= lane_q[i];
  end

  // Unused codes above CHANNELS-1 collapse onto the last channel.
  assign sel_c = (sel > LAST) ? LAST : sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y       <= '0;
      y_valid <= 1'b0;
      cur_sel <= '0;
      wrap    <= 1'b0;
      cnt     <= '0;
      mode_q  <= 1'b0;
    end else if (!en) begin
      y_valid <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      y       <= y_nxt;
      y_valid <= 1'b1;
      wrap    <= 1'b0;
      mode_q  <= mode;
      if (!mode) begin
        cnt <= '0;
        if (load) cur_sel <= sel_c;
      end else if (load) begin
        cur_sel <= sel_c;
        cnt     <= '0;
      end else if (!mode_q) begin
        // Entering scan: restart the dwell on whatever channel is current.
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt <= '0;
        if (cur_sel == LAST) begin
          cur_sel <= '0;
          wrap    <= 1'b1;
        end else begin
          cur_sel <= cur_sel + 1'b1;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule
